// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the CPU's single unified memory port between the CPU datapath
// (requester 0: fetch and load/store) and the debug/loader port
// (requester 1). One request at a time is accepted in S_IDLE and latched.
// The latched request is then held on the memory for MEM_LATENCY cycles in
// S_ACCESS. Read data, or 0 for a write, is returned with a one-cycle rvalid
// pulse in S_RESP.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, debug wins over CPU.
//   defined   : round robin. A tie goes to the requester that did not own
//               the previous transfer. The CPU wins the first tie after reset.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_gnt
//   cpu_gnt                  CPU request accepted (combinational, S_IDLE only)
//   cpu_rvalid/cpu_rdata     CPU completion pulse and read data
//   cpu_stall                hold the controller FSM while a CPU access is
//                            pending or in flight
//   dbg_req/we/addr/wdata    debug request, held until dbg_gnt
//   dbg_gnt                  debug request accepted
//   dbg_rvalid/dbg_rdata     debug completion pulse and read data
//   mem_en/we/addr/wdata     memory command (mem_we only in first access cycle)
//   mem_rdata                memory read data, valid MEM_LATENCY cycles after
//                            mem_en first rises
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Loaded on grant; the access ends when it reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  // Per-requester copies so a non-owner's rdata keeps its last value.
  logic [DW-1:0] cpu_hold_q, cpu_hold_d;
  logic [DW-1:0] dbg_hold_q, dbg_hold_d;

  logic win_dbg;
  logic in_idle;
  logic in_access;
  logic in_resp;

  assign in_idle   = (state_q == S_IDLE);
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // Round-robin winner: on a tie, the requester that did not go last.
  always_comb begin
    if (cpu_req && dbg_req) begin
      win_dbg = (last_owner_q == OWN_CPU);
    end else begin
      win_dbg = dbg_req;
    end
  end

  // Remember who owned the transfer that is completing.
  always_comb begin
    if (in_resp) begin
      last_owner_d = owner_q;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // last_owner register; DBG after reset so the CPU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_DBG;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Fixed priority: debug always beats the CPU.
  always_comb begin
    win_dbg = dbg_req;
  end
`endif

  // Next-state logic for the transfer FSM and its latches.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cpu_hold_d = cpu_hold_q;
    dbg_hold_d = dbg_hold_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = win_dbg ? OWN_DBG : OWN_CPU;
          we_d    = win_dbg ? dbg_we : cpu_we;
          addr_d  = win_dbg ? dbg_addr : cpu_addr;
          wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_ACCESS;
        end
      end
      S_RESP: begin
        // The owner's copy takes the response so it persists afterwards.
        if (owner_q == OWN_CPU) begin
          cpu_hold_d = rdata_q;
        end else begin
          dbg_hold_d = rdata_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_CPU;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
    end
  end

  // Grants are combinational from req; masked during reset so every output
  // is 0 while reset is high.
  assign cpu_gnt = ~reset & in_idle & cpu_req & ~win_dbg;
  assign dbg_gnt = ~reset & in_idle & dbg_req & win_dbg;

  assign cpu_rvalid = in_resp & (owner_q == OWN_CPU);
  assign dbg_rvalid = in_resp & (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? rdata_q : cpu_hold_q;
  assign dbg_rdata  = dbg_rvalid ? dbg_hold_q_or_rdata() : dbg_hold_q;

  function automatic logic [DW-1:0] dbg_hold_q_or_rdata();
    return rdata_q;
  endfunction

  // Stall drops in the rvalid cycle so the controller advances on that edge.
  assign cpu_stall = ~reset & ~cpu_rvalid &
                     (cpu_req | (~in_idle & (owner_q == OWN_CPU)));

  // The write strobe is limited to the first access cycle so each write
  // reaches memory exactly once.
  assign mem_en    = in_access;
  assign mem_we    = in_access & we_q & (cnt_q == CNT_INIT);
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'd0, dbg_wdata = 32'd0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Small memory: 16 words selected by addr[5:2], unwritten words read a pattern.
  function automatic logic [31:0] init_word(input logic [3:0] idx);
    return 32'h1000_0001 * ({28'd0, idx} + 32'd7);
  endfunction

  logic [31:0] tb_mem [16];
  logic [15:0] mem_written = 16'd0;
  assign mem_rdata = mem_written[mem_addr[5:2]] ? tb_mem[mem_addr[5:2]] : init_word(mem_addr[5:2]);
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      tb_mem[mem_addr[5:2]]      <= mem_wdata;
      mem_written[mem_addr[5:2]] <= 1'b1;
    end
  end

  // Transaction-level model: a grant at cycle g owns the port until g+LAT+1.
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, free_at = 0, g = 0;
  bit          have_txn = 0, t_dbg = 0, t_we = 0, last_dbg = 1;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [31:0] m_mem [16];
  bit   [15:0] m_written = 16'd0;
  logic [31:0] e_cpu_rdata = 32'd0, e_dbg_rdata = 32'd0;
  bit          cpu_g_last = 0, dbg_g_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Evaluate the model for the current cycle and compare every output.
  task automatic cyc_end();
    bit          e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_stall, cpu_busy;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  idx;
    @(negedge clk);
    cyc++;
    e_cg = 0; e_dg = 0; e_en = 0; e_we = 0; e_crv = 0; e_drv = 0; e_stall = 0; cpu_busy = 0;
    if (reset) begin
      have_txn = 0; free_at = 0; last_dbg = 1;
      e_cpu_rdata = 32'd0; e_dbg_rdata = 32'd0;
    end else begin
      if (cyc >= free_at && (cpu_req || dbg_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        t_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;
`else
        t_dbg = dbg_req;
`endif
        e_cg = !t_dbg; e_dg = t_dbg;
        t_we    = t_dbg ? dbg_we : cpu_we;
        t_addr  = t_dbg ? dbg_addr : cpu_addr;
        t_wdata = t_dbg ? dbg_wdata : cpu_wdata;
        idx     = t_addr[5:2];
        t_rdata = t_we ? 32'd0 : (m_written[idx] ? m_mem[idx] : init_word(idx));
        if (t_we) begin
          m_mem[idx] = t_wdata;
          m_written[idx] = 1'b1;
        end
        g = cyc; free_at = cyc + LAT + 2; have_txn = 1;
      end
      if (have_txn) begin
        e_en = (cyc > g) && (cyc <= g + LAT);
        e_we = e_en && t_we && (cyc == g + 1);
        if (cyc == g + LAT + 1) begin
          if (t_dbg) begin e_drv = 1; e_dbg_rdata = t_rdata; end
          else begin e_crv = 1; e_cpu_rdata = t_rdata; end
          last_dbg = t_dbg;
        end
        cpu_busy = !t_dbg && (cyc > g) && (cyc <= g + LAT + 1);
      end
      e_stall = !e_crv && (cpu_req || cpu_busy);
    end
    e_addr = e_en ? t_addr : 32'd0;
    e_wd   = e_en ? t_wdata : 32'd0;
    chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cg});
    chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e_dg});
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_crv});
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e_drv});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("dbg_rdata", dbg_rdata, e_dbg_rdata);
    cpu_g_last = e_cg; dbg_g_last = e_dg;
  endtask

  // One cycle of requester behaviour: drop req after grant, optionally random.
  task automatic drive_cycle(input bit rnd, input bit hold);
    @(posedge clk); #1;
    if (cpu_g_last && !hold) cpu_req = 1'b0;
    else if (rnd && cpu_req && $urandom_range(0, 19) == 0) cpu_req = 1'b0;
    else if (rnd && !cpu_req && $urandom_range(0, 2) == 0) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = $urandom() & 32'hFFFF_FFFC; cpu_wdata = $urandom();
    end
    if (dbg_g_last && !hold) dbg_req = 1'b0;
    else if (rnd && dbg_req && $urandom_range(0, 19) == 0) dbg_req = 1'b0;
    else if (rnd && !dbg_req && $urandom_range(0, 3) == 0) begin
      dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = $urandom() & 32'hFFFF_FFFC; dbg_wdata = $urandom();
    end
    cyc_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cg, dg, drv, stall_lo, we_cnt, rv_at, ng;
    logic [3:0] order;

    // Reset state.
    repeat (3) begin @(posedge clk); #1; cyc_end(); end
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1; reset = 1'b0; cyc_end();

    // Loader writes 0xDEADBEEF to 0x10.
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF;
    cyc_end();
    chk("load_gnt", {31'd0, dbg_gnt}, 32'd1);
    repeat (LAT + 1) drive_cycle(0, 0);

    // CPU read of 0x10.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cyc_end();
    chk("rd_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("rd_stall_gnt", {31'd0, cpu_stall}, 32'd1);
    for (int i = 1; i <= LAT; i++) begin
      drive_cycle(0, 0);
      chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
      chk("rd_stall_acc", {31'd0, cpu_stall}, 32'd1);
      chk("rd_mem_addr", mem_addr, 32'h10);
    end
    drive_cycle(0, 0);
    chk("rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd_stall_rv", {31'd0, cpu_stall}, 32'd0);

    // Debug write of 0x12345678 to 0x20.
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    cyc_end();
    chk("wr_gnt", {31'd0, dbg_gnt}, 32'd1);
    we_cnt = 0; rv_at = -1;
    for (int i = 1; i <= LAT + 1; i++) begin
      drive_cycle(0, 0);
      if (mem_we) begin
        we_cnt++;
        chk("wr_addr", mem_addr, 32'h20);
        chk("wr_data", mem_wdata, 32'h12345678);
      end
      if (dbg_rvalid) rv_at = i;
    end
    chk("wr_we_count", 32'(we_cnt), 32'd1);
    chk("wr_rv_latency", 32'(rv_at), 32'(LAT + 1));
    chk("wr_rdata", dbg_rdata, 32'd0);

    // Simultaneous requests.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    cyc_end();
    cg = cpu_gnt ? 0 : -1; dg = dbg_gnt ? 0 : -1; drv = -1; stall_lo = 0;
    for (int i = 1; i <= 2 * LAT + 6; i++) begin
      drive_cycle(0, 0);
      if (cpu_gnt && cg < 0) cg = i;
      if (dbg_gnt && dg < 0) dg = i;
      if (dbg_rvalid && drv < 0) drv = i;
      if (cg < 0 && !cpu_stall) stall_lo++;
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_cpu_gnt_at", 32'(cg), 32'd0);
    chk("tie_dbg_gnt_at", 32'(dg), 32'(LAT + 2));
`else
    chk("tie_dbg_gnt_at", 32'(dg), 32'd0);
    chk("tie_cpu_gnt_at", 32'(cg), 32'(LAT + 2));
    chk("tie_cpu_after_rv", 32'(cg), 32'(drv + 1));
`endif
    chk("tie_stall_held", 32'(stall_lo), 32'd0);

    // Both requesters held high for four transfers.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    cyc_end();
    order = 4'd0; ng = 0;
    if (cpu_gnt || dbg_gnt) begin order[0] = dbg_gnt; ng = 1; end
    for (int i = 1; i < 4 * (LAT + 2); i++) begin
      drive_cycle(0, 1);
      if (cpu_gnt || dbg_gnt) begin
        if (ng < 4) order[ng] = dbg_gnt;
        ng++;
      end
    end
    @(posedge clk); #1; cpu_req = 1'b0; dbg_req = 1'b0; cyc_end();
    chk("hold_grant_count", 32'(ng), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    chk("hold_order", {28'd0, order}, 32'h0000000A);
`else
    chk("hold_order", {28'd0, order}, 32'h0000000F);
`endif
    repeat (LAT + 2) drive_cycle(0, 0);

    // Reset during the second access cycle of a CPU read.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    cyc_end();
    chk("rst_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
    drive_cycle(0, 0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h34;
    #2; reset = 1'b1;
    cyc_end();
    chk("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mid_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1; cyc_end();
    @(posedge clk); #1; reset = 1'b0; cyc_end();
    chk("rst_regrant", {31'd0, cpu_gnt}, 32'd1);
    repeat (LAT + 1) drive_cycle(0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) drive_cycle(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the multi-cycle CPU's single unified memory port between two requesters. Requester 0 is the CPU datapath, covering fetch and load/store addresses. Requester 1 is the debug/loader port. A three-state FSM latches one request, holds the memory for a fixed latency, returns read data or a write acknowledge, and drives a stall to the controller FSM so it holds its current state while waiting.

Parameters:
MEM_LATENCY, 2, memory cycles from mem_en to valid mem_rdata; legal range 1..15
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU request; held until cpu_gnt
cpu_we  in  1  CPU write enable (1 = store)
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU request accepted this cycle
cpu_rvalid  out  1  CPU transfer complete, 1-cycle pulse
cpu_rdata  out  DW  CPU read data, valid with cpu_rvalid
cpu_stall  out  1  hold the controller FSM state
dbg_req  in  1  debug request; held until dbg_gnt
dbg_we  in  1  debug write enable
dbg_addr  in  AW  debug address
dbg_wdata  in  DW  debug write data
dbg_gnt  out  1  debug request accepted
dbg_rvalid  out  1  debug transfer complete, 1-cycle pulse
dbg_rdata  out  DW  debug read data
mem_en  out  1  memory access active
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high.
  - state=S_IDLE, owner=CPU, last_owner=DBG, cnt=0.
  - Latched addr, wdata, we, and rdata registers are cleared to 0.
  - All outputs are 0.
- States: S_IDLE, S_ACCESS, S_RESP.
- S_IDLE:
  - If any req is high, select a winner. Default is fixed priority, dbg over cpu.
  - Assert the winner's gnt combinationally in that cycle. The loser's gnt stays 0.
  - On the clock edge, latch owner, we, addr, wdata; set cnt=MEM_LATENCY-1; go to S_ACCESS.
  - If no req is high, remain in S_IDLE.
- S_ACCESS:
  - mem_en=1; mem_addr and mem_wdata come from the latches.
  - mem_we=latched we only in the first S_ACCESS cycle, so each write is issued exactly once.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata into the rdata register (0 for writes) and go to S_RESP.
- S_RESP:
  - Owner's rvalid=1 for exactly one cycle; owner's rdata=rdata register.
  - Non-owner rvalid=0; non-owner rdata holds its previous value.
  - Write completions also pulse rvalid, with rdata=0.
  - Next state is S_IDLE.
- Latency: gnt cycle to rvalid cycle = MEM_LATENCY+1. Minimum spacing between grants = MEM_LATENCY+2 cycles.
- Request timing:
  - A req that rises while the port is busy waits in S_IDLE for arbitration. It is never dropped.
  - req inputs are sampled only in S_IDLE.
  - Deasserting req before gnt withdraws it legally.
  - Changing addr, we, or wdata while req is high and gnt is low is illegal.
- cpu_stall = (cpu_req & ~cpu_rvalid) | (state!=S_IDLE & owner==CPU & ~cpu_rvalid).
  - Asserted while a CPU request is pending or in flight.
  - Low in the cpu_rvalid cycle, so the controller advances on that edge.
- Simultaneous cpu_req and dbg_req in S_IDLE: only one gnt is asserted. The loser stays stalled.
- Reset mid-transfer: FSM aborts to S_IDLE and no rvalid is produced. A write already strobed to memory is not undone.
- MEM_LATENCY=1: S_ACCESS lasts exactly one cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration.
  - last_owner updates to owner on the S_RESP edge.
  - When both requesters are high in S_IDLE, the grant goes to the requester that is not last_owner.
  - With last_owner=DBG after reset, the CPU wins the first tie.
  - A single requester is always granted.
- Undefined: fixed priority, dbg over cpu. The last_owner register is not built.

Test Plan:
- MEM_LATENCY=2. cpu_req=1, we=0, addr=0x10, memory returns 0xDEADBEEF.
  -> cpu_gnt at cycle 0, mem_en cycles 1-2, cpu_rvalid at cycle 3 with rdata=0xDEADBEEF.
  -> cpu_stall=1 on cycles 0-2 and 0 on cycle 3.
- dbg write addr=0x20, wdata=0x12345678.
  -> mem_we=1 for exactly one cycle with those values.
  -> dbg_rvalid 3 cycles after dbg_gnt with rdata=0.
- cpu_req and dbg_req rise together, fixed priority.
  -> dbg granted first; cpu_gnt comes in the first S_IDLE cycle after dbg_rvalid.
  -> cpu_stall stays high throughout the dbg transfer.
- ARB_ROUND_ROBIN_EN defined, both requesters held high continuously, 4 transfers.
  -> grant order CPU, DBG, CPU, DBG.
- reset asserted during the second S_ACCESS cycle of a CPU read.
  -> all outputs 0 immediately, no cpu_rvalid.
  -> after release, a new cpu_req is granted normally.
- MEM_LATENCY=1, back-to-back CPU reads to 0x0 then 0x4.
  -> rvalid arrives 2 cycles after each gnt; the second gnt comes 3 cycles after the first.
